// File: rtl/mpexch_if.sv
// ============================================================================
// Module      : mpexch_if
// Description : CPU/PP exchange bus bundle for the mpexch block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mpexch_if;
  // CPU (microcode) side
  logic        cpu_wr;
  logic [3:0]  cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_send;
  logic [63:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_free;
  logic        run;
  // Peripheral-processor side
  logic [5:0]  pp_addr;
  logic        pp_rd;
  logic        pp_wr;
  logic [15:0] pp_wdata;
  logic [15:0] pp_rdata;
  logic        pp_done;
  logic        pp_go;
  logic        pp_irq;

  modport master (
    output cpu_wr, cpu_addr, cpu_wdata, cpu_send, cpu_ack,
    output pp_addr, pp_rd, pp_wr, pp_wdata, pp_done, pp_go,
    input  cpu_rdata, cpu_free, run, pp_rdata, pp_irq
  );

  modport slave (
    input  cpu_wr, cpu_addr, cpu_wdata, cpu_send, cpu_ack,
    input  pp_addr, pp_rd, pp_wr, pp_wdata, pp_done, pp_go,
    output cpu_rdata, cpu_free, run, pp_rdata, pp_irq
  );
endinterface

`default_nettype wire

// File: rtl/mpexch.sv
// ============================================================================
// Module      : mpexch
// Description : CPU<->PP exchange RAM (16x64) with CPMP/RUN handshake flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpexch (
  input  logic     clk,
  input  logic     reset,
  mpexch_if.slave  bus
);

  localparam logic [0:0] c_ST_FREE = 1'b0;
  localparam logic [0:0] c_ST_FULL = 1'b1;

  logic [0:0]  r_state;
  logic        r_run;
  logic [63:0] r_mem [16];
  logic [63:0] r_cpu_rdata;
  logic [15:0] r_pp_rdata;

  logic        w_cpu_wr_ok;
  logic        w_pp_wr_ok;
  logic [3:0]  w_pp_word;
  logic [5:0]  w_pp_lsb;
  logic [15:0] w_pp_rd_lane;

  // Each side may only write its own half, and only while its buffer is open.
  assign w_cpu_wr_ok  = bus.cpu_wr && !bus.cpu_addr[3] && (r_state == c_ST_FREE);
  assign w_pp_wr_ok   = bus.pp_wr && bus.pp_addr[5] && !r_run;
  assign w_pp_word    = bus.pp_addr[5:2];
  assign w_pp_lsb     = {bus.pp_addr[1:0], 4'b0000};
  assign w_pp_rd_lane = r_mem[w_pp_word][w_pp_lsb +: 16];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_FREE;
    end else begin
      case (r_state)
        c_ST_FREE: if (bus.cpu_send) r_state <= c_ST_FULL;
        c_ST_FULL: if (bus.pp_done)  r_state <= c_ST_FREE;
        default:                     r_state <= c_ST_FREE;
      endcase
    end
  end

  // ack wins over a coincident go: the PP must repost after the CPU consumes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run <= 1'b0;
    end else if (r_run) begin
      if (bus.cpu_ack) r_run <= 1'b0;
    end else begin
      if (bus.pp_go) r_run <= 1'b1;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_cpu_wr_ok) begin
        r_mem[{1'b0, bus.cpu_addr[2:0]}] <= bus.cpu_wdata;
      end
      if (w_pp_wr_ok) begin
        r_mem[w_pp_word][w_pp_lsb +: 16] <= bus.pp_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_rdata <= 64'd0;
      r_pp_rdata  <= 16'd0;
    end else begin
      r_cpu_rdata <= r_mem[bus.cpu_addr];
      if (bus.pp_rd) begin
        r_pp_rdata <= w_pp_rd_lane;
      end
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.pp_rdata  = r_pp_rdata;
  assign bus.cpu_free  = (r_state == c_ST_FREE);
  assign bus.pp_irq    = (r_state == c_ST_FULL);
  assign bus.run       = r_run;

endmodule

`default_nettype wire

// File: tb/tb_mpexch.sv
// ============================================================================
// Module      : tb_mpexch
// Description : Directed vector bench for mpexch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpexch;

  logic clk;
  logic reset;
  mpexch_if bus ();

  mpexch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        cpu_wr;
    logic [3:0]  cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_send;
    logic        cpu_ack;
    logic [5:0]  pp_addr;
    logic        pp_rd;
    logic        pp_wr;
    logic [15:0] pp_wdata;
    logic        pp_done;
    logic        pp_go;
    logic        e_free;
    logic        e_run;
    logic        e_irq;
    logic        chk_c;
    logic [63:0] e_crd;
    logic        chk_p;
    logic [15:0] e_prd;
  } vec_t;

  vec_t vq[$];
  vec_t v;
  int   n_tests;
  int   n_fail;

  function automatic vec_t blank(input logic free, input logic run_f);
    vec_t b;
    b = '{default: '0};
    b.e_free = free;
    b.e_irq  = !free;
    b.e_run  = run_f;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t d);
    bus.cpu_wr    = d.cpu_wr;
    bus.cpu_addr  = d.cpu_addr;
    bus.cpu_wdata = d.cpu_wdata;
    bus.cpu_send  = d.cpu_send;
    bus.cpu_ack   = d.cpu_ack;
    bus.pp_addr   = d.pp_addr;
    bus.pp_rd     = d.pp_rd;
    bus.pp_wr     = d.pp_wr;
    bus.pp_wdata  = d.pp_wdata;
    bus.pp_done   = d.pp_done;
    bus.pp_go     = d.pp_go;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // CPU->PP message
    v = blank(1, 0); v.cpu_wr = 1; v.cpu_addr = 2; v.cpu_wdata = 64'hAAAA_BBBB_CCCC_DDDD; vq.push_back(v);
    v = blank(1, 0); v.cpu_wr = 1; v.cpu_addr = 3; v.cpu_wdata = 64'h0123_4567_89AB_CDEF; vq.push_back(v);
    v = blank(0, 0); v.cpu_send = 1; v.cpu_addr = 3;
    v.chk_c = 1; v.e_crd = 64'h0123_4567_89AB_CDEF; vq.push_back(v);
    v = blank(0, 0); v.pp_rd = 1; v.pp_addr = {4'd3, 2'd1};
    v.chk_p = 1; v.e_prd = 16'h89AB; vq.push_back(v);
    // Blocked writes while FULL
    v = blank(0, 0); v.cpu_wr = 1; v.cpu_addr = 3; v.cpu_wdata = 64'd0; v.cpu_send = 1; vq.push_back(v);
    v = blank(0, 0); v.cpu_addr = 3; v.pp_wr = 1; v.pp_addr = {4'd2, 2'd0}; v.pp_wdata = 16'h1234;
    v.chk_c = 1; v.e_crd = 64'h0123_4567_89AB_CDEF; vq.push_back(v);
    v = blank(0, 0); v.pp_rd = 1; v.pp_addr = {4'd2, 2'd0};
    v.chk_p = 1; v.e_prd = 16'hDDDD; vq.push_back(v);
    v = blank(1, 0); v.pp_done = 1; vq.push_back(v);
    // PP->CPU message
    v = blank(1, 0); v.pp_wr = 1; v.pp_addr = {4'd9, 2'd0}; v.pp_wdata = 16'h1111; vq.push_back(v);
    v = blank(1, 0); v.pp_wr = 1; v.pp_addr = {4'd9, 2'd1}; v.pp_wdata = 16'h2222; vq.push_back(v);
    v = blank(1, 0); v.pp_wr = 1; v.pp_addr = {4'd9, 2'd2}; v.pp_wdata = 16'h3333; vq.push_back(v);
    v = blank(1, 0); v.pp_wr = 1; v.pp_addr = {4'd9, 2'd3}; v.pp_wdata = 16'h4444; vq.push_back(v);
    v = blank(1, 1); v.pp_go = 1; v.cpu_addr = 9;
    v.chk_c = 1; v.e_crd = 64'h4444_3333_2222_1111; vq.push_back(v);
    v = blank(1, 1); v.pp_wr = 1; v.pp_addr = {4'd9, 2'd0}; v.pp_wdata = 16'hFFFF; vq.push_back(v);
    v = blank(1, 1); v.cpu_addr = 9;
    v.chk_c = 1; v.e_crd = 64'h4444_3333_2222_1111; vq.push_back(v);
    v = blank(1, 0); v.cpu_ack = 1; vq.push_back(v);
    v = blank(1, 0); v.cpu_ack = 1; vq.push_back(v);
    // Collisions
    v = blank(0, 0); v.cpu_send = 1; vq.push_back(v);
    v = blank(1, 0); v.pp_done = 1; v.cpu_send = 1; vq.push_back(v);
    v = blank(1, 0); v.pp_done = 1; vq.push_back(v);
    v = blank(0, 1); v.cpu_wr = 1; v.cpu_addr = 5; v.cpu_wdata = 64'h5555_6666_7777_8888;
    v.cpu_send = 1; v.pp_go = 1; vq.push_back(v);
    v = blank(0, 0); v.cpu_addr = 5; v.cpu_ack = 1; v.pp_go = 1;
    v.chk_c = 1; v.e_crd = 64'h5555_6666_7777_8888; vq.push_back(v);
    v = blank(0, 1); v.pp_wr = 1; v.pp_rd = 1; v.pp_addr = {4'd9, 2'd1}; v.pp_wdata = 16'hBEEF;
    v.pp_go = 1; v.chk_p = 1; v.e_prd = 16'h2222; vq.push_back(v);
    v = blank(0, 1); v.pp_rd = 1; v.pp_addr = {4'd9, 2'd1}; v.cpu_addr = 9;
    v.chk_c = 1; v.e_crd = 64'h4444_3333_BEEF_1111; v.chk_p = 1; v.e_prd = 16'hBEEF; vq.push_back(v);
    v = blank(0, 1); v.pp_rd = 1; v.pp_addr = {4'd0, 2'd0}; v.pp_wr = 1; v.pp_wdata = 16'h0BAD;
    v.chk_p = 1; v.e_prd = 16'hDDDD; v.pp_addr = {4'd2, 2'd0}; vq.push_back(v);

    reset = 1'b1;
    drive(blank(1, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_cpu_free", 64'(bus.cpu_free), 64'd1);
    check("reset_run", 64'(bus.run), 64'd0);
    check("reset_pp_irq", 64'(bus.pp_irq), 64'd0);
    check("reset_cpu_rdata", bus.cpu_rdata, 64'd0);
    check("reset_pp_rdata", 64'(bus.pp_rdata), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cpu_free", i), 64'(bus.cpu_free), 64'(vq[i].e_free));
      check($sformatf("v%0d_pp_irq", i), 64'(bus.pp_irq), 64'(vq[i].e_irq));
      check($sformatf("v%0d_run", i), 64'(bus.run), 64'(vq[i].e_run));
      if (vq[i].chk_c) check($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vq[i].e_crd);
      if (vq[i].chk_p) check($sformatf("v%0d_pp_rdata", i), 64'(bus.pp_rdata), 64'(vq[i].e_prd));
    end

    // Reset mid-operation: FULL and run pending, storage must survive
    drive(blank(1, 0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_cpu_free", 64'(bus.cpu_free), 64'd1);
    check("midreset_run", 64'(bus.run), 64'd0);
    check("midreset_pp_irq", 64'(bus.pp_irq), 64'd0);
    check("midreset_pp_rdata", 64'(bus.pp_rdata), 64'd0);
    reset = 1'b0;
    v = blank(1, 0); v.cpu_addr = 3;
    drive(v);
    @(posedge clk);
    #1;
    check("retain_word3", bus.cpu_rdata, 64'h0123_4567_89AB_CDEF);
    v = blank(1, 0); v.cpu_addr = 9; v.pp_rd = 1; v.pp_addr = {4'd3, 2'd3};
    drive(v);
    @(posedge clk);
    #1;
    check("retain_word9", bus.cpu_rdata, 64'h4444_3333_BEEF_1111);
    check("retain_pp_word3_lane3", 64'(bus.pp_rdata), 64'h0123);
    check("post_reset_free", 64'(bus.cpu_free), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mpexch.md
# mpexch

CPU↔peripheral-processor (ПП) exchange block: the PP-facing end of the exchange RAM that microcode addresses through MPADR. It receives 64-bit message words written by the CPU microprogram, exposes them to the 16-bit PP bus, and raises the CPMP ("ОЗУ обмена ЦП→ПП свободно") condition when the PP releases the buffer. In the reverse direction it collects a PP→CPU message and raises the RUN condition until microcode acknowledges it.

## Interface
No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_wr  in  1  write cpu_wdata to CPU→PP word cpu_addr[2:0]
- cpu_addr  in  4  MPADR; bit 3 selects PP→CPU half for reads
- cpu_wdata  in  64  data from Y bus
- cpu_send  in  1  post CPU→PP message
- cpu_rdata  out  64  registered read of word cpu_addr (all 16 words)
- cpu_ack  in  1  consume PP→CPU message, clears run
- cpu_free  out  1  CPMP condition: CPU→PP buffer free
- run  out  1  RUN condition: PP→CPU message pending
- pp_addr  in  6  [5:2] word 0–15, [1:0] 16-bit lane (lane 0 = bits 15:0)
- pp_rd  in  1  read strobe
- pp_wr  in  1  write strobe
- pp_wdata  in  16  PP write data
- pp_rdata  out  16  registered read data
- pp_done  in  1  PP releases CPU→PP buffer
- pp_go  in  1  PP posts PP→CPU message
- pp_irq  out  1  CPU→PP message pending (interrupt to PP)

## Operation
- Storage: 16×64-bit words. Words 0–7: CPU→PP buffer (CPU writes, PP reads). Words 8–15: PP→CPU buffer (PP writes, CPU reads). Both sides may read any word. Contents not cleared by reset.
- CPU→PP FSM, two states:
  - FREE: cpu_free=1, pp_irq=0. cpu_wr to words 0–7 accepted (cpu_addr[3]=1 write ignored). cpu_send → FULL.
  - FULL: cpu_free=0, pp_irq=1. cpu_wr and cpu_send ignored. pp_done → FREE.
  - pp_done in FREE ignored.
- PP→CPU flag run:
  - run=0: pp_wr to words 8–15 merges pp_wdata into selected lane, other lanes unchanged. pp_go sets run.
  - run=1: pp_wr to 8–15 and pp_go ignored. cpu_ack clears run.
  - cpu_ack with run=0 ignored.
  - pp_wr to words 0–7 always ignored.
- Simultaneous events, decided on state at the clock edge:
  - cpu_wr+cpu_send in FREE: word written and message posted in the same edge.
  - pp_done+cpu_send in FULL: buffer freed; send ignored (must be reissued).
  - cpu_ack+pp_go with run=1: run cleared; go ignored.
  - pp_wr+pp_go with run=0: write lands, run sets.
  - pp_rd+pp_wr same cycle: pp_rdata returns pre-write data.
- Read ports: cpu_rdata ← word[cpu_addr] every cycle; pp_rdata ← lane of word[pp_addr[5:2]] on pp_rd, else holds.

## Timing
- Reset values: cpu_free=1, pp_irq=0, run=0, cpu_rdata=0, pp_rdata=0; FSM in FREE. Reset asserted mid-message discards pending FULL/run immediately at that edge.
- cpu_send at edge N: cpu_free=0, pp_irq=1 from cycle N+1 (microcode testing CPMP in cycle N+1 sees busy).
- pp_done at edge N: cpu_free=1, pp_irq=0 from N+1.
- pp_go at edge N: run=1 from N+1; cpu_ack at edge M: run=0 from M+1.
- Read latency 1 cycle on both ports; a write at edge N is visible to a read issued at edge N+1 (returned after N+1).
- No wait states; every strobe completes in one cycle.

## Test plan
- Reset: reset 2 cycles → cpu_free=1, run=0, pp_irq=0, cpu_rdata=0, pp_rdata=0.
- CPU→PP: cpu_wr word 3 = 64'h0123_4567_89AB_CDEF, cpu_send → next cycle pp_irq=1, cpu_free=0; pp_rd addr {3,2'd1} → pp_rdata=16'h89AB one cycle later; pp_done → cpu_free=1, pp_irq=0.
- Blocked writes: in FULL, cpu_wr word 3 = 0 and cpu_send → word 3 still 64'h0123…CDEF, state stays FULL; pp_wr to word 2 → unchanged.
- PP→CPU: pp_wr word 9 lanes 0..3 = 16'h1111,2222,3333,4444, pp_go → run=1; cpu_addr=9 → cpu_rdata=64'h4444_3333_2222_1111; pp_wr lane 0 = 16'hFFFF while run=1 ignored; cpu_ack → run=0.
- Collisions: FULL with pp_done+cpu_send same cycle → FREE, cpu_free=1; run=1 with cpu_ack+pp_go → run=0 next cycle.
- Reset mid-operation: FULL and run=1, assert reset one cycle → cpu_free=1, run=0, pp_irq=0; stored words 3 and 9 retain values.
